n4_b2_up_counter: RTL and testbench

//   Synchronous 4-digit base-2 (modulo-16) up counter with count-enable input
//   and carry output, for cascading into wider counters or timing chains.

---
 rtl/n4_b2_up_counter.sv | 35 +++
 tb/tb_n4_b2_up_counter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/n4_b2_up_counter.sv
// Four-digit base-2 (modulo-16) up counter with count enable and combinational carry out.
// Each binary digit toggles when its incoming ripple enable is high and passes the enable on while it holds a one.
module n4_b2_up_counter (
    input  logic       m_clock,
    input  logic       m_reset_,
    input  logic       m_ei,
    output logic       eu,
    output logic [3:0] q3_q0
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [4:0] carry;

    assign carry[0] = m_ei;

    // Digit i sees an enable only when m_ei is high and every lower digit is one.
    for (genvar i = 0; i < 4; i++) begin : g_digit
        assign carry[i+1] = carry[i] & cnt_q[i];
        assign cnt_d[i]   = cnt_q[i] ^ carry[i];
    end

    always_ff @(posedge m_clock or negedge m_reset_) begin
        if (!m_reset_) begin
            cnt_q <= 4'b0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // eu is left unregistered so that a cascaded stage advances on the same edge that this counter wraps.
    assign eu    = carry[4];
    assign q3_q0 = cnt_q;

endmodule

// File: tb/tb_n4_b2_up_counter.sv
// Self-checking bench for n4_b2_up_counter: timed long run, a table of vectors
// applied through a scoreboard queue, and hand-written async-reset/carry corners.
`timescale 1ns/1ps
module tb_n4_b2_up_counter;

    logic       m_clock;
    logic       m_reset_;
    logic       m_ei;
    logic       eu;
    logic [3:0] q3_q0;

    int errors;
    int checks;

    typedef struct {
        logic       rst;
        logic       ei;
        logic [3:0] q;
        logic       eu;
    } vec_t;

    typedef struct {
        logic [3:0] q;
        logic       eu;
        int         idx;
    } exp_t;

    vec_t vecs[64];
    int   nVec;
    exp_t sbQ[$];
    int   stepIdx;

    n4_b2_up_counter dut (
        .m_clock  (m_clock),
        .m_reset_ (m_reset_),
        .m_ei     (m_ei),
        .eu       (eu),
        .q3_q0    (q3_q0)
    );

    // 10 ns period: rising edges at 5, 15, 25, ...
    initial begin
        m_clock = 1'b0;
        forever #5 m_clock = ~m_clock;
    end

    // Guarantees termination even if some edge-wait misbehaves.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function void addVec(input logic rst, input logic ei, input logic [3:0] q, input logic e);
        vecs[nVec].rst = rst;
        vecs[nVec].ei  = ei;
        vecs[nVec].q   = q;
        vecs[nVec].eu  = e;
        nVec++;
    endfunction

    task checkValue(input string name, input logic [3:0] expQ, input logic expEu);
        checks++;
        if (q3_q0 !== expQ || eu !== expEu) begin
            errors++;
            $display("[TB] FAIL %s: got q=%0d eu=%b, expected q=%0d eu=%b", name, q3_q0, eu, expQ, expEu);
        end
    endtask

    // Pops the oldest expectation and compares it with what the DUT shows now.
    task checkOutput();
        exp_t e;
        checks++;
        if (sbQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: queue empty at step %0d", stepIdx);
        end else begin
            e = sbQ.pop_front();
            if (q3_q0 !== e.q || eu !== e.eu) begin
                errors++;
                $display("[TB] FAIL step%0d: got q=%0d eu=%b, expected q=%0d eu=%b", e.idx, q3_q0, eu, e.q, e.eu);
            end
        end
    endtask

    // Drives inputs on the falling edge, queues the expectation, samples 1 ns after the rising edge.
    task applyStimulus(input logic rst, input logic ei, input logic [3:0] expQ, input logic expEu);
        exp_t e;
        @(negedge m_clock);
        m_reset_ = rst;
        m_ei     = ei;
        e.q   = expQ;
        e.eu  = expEu;
        e.idx = stepIdx;
        sbQ.push_back(e);
        @(posedge m_clock);
        #1;
        checkOutput();
        stepIdx++;
    endtask

    initial begin
        int euPulses;
        errors   = 0;
        checks   = 0;
        nVec     = 0;
        stepIdx  = 0;
        euPulses = 0;

        addVec(1'b0, 1'b0, 4'd0, 1'b0);
        addVec(1'b0, 1'b1, 4'd0, 1'b0);
        addVec(1'b1, 1'b0, 4'd0, 1'b0);
        for (int k = 1; k <= 15; k++) addVec(1'b1, 1'b1, 4'(k), 1'(k == 15));
        addVec(1'b1, 1'b1, 4'd0, 1'b0);
        for (int k = 1; k <= 7; k++) addVec(1'b1, 1'b1, 4'(k), 1'b0);
        for (int k = 0; k < 5; k++) addVec(1'b1, 1'b0, 4'd7, 1'b0);
        for (int k = 8; k <= 15; k++) addVec(1'b1, 1'b1, 4'(k), 1'(k == 15));
        addVec(1'b1, 1'b0, 4'd15, 1'b0);
        addVec(1'b1, 1'b1, 4'd0, 1'b0);
        for (int k = 1; k <= 9; k++) addVec(1'b1, 1'b1, 4'(k), 1'b0);

        // Long run: reset low until t=10 with m_ei high, 20 edges from t=15 to t=205.
        m_reset_ = 1'b0;
        m_ei     = 1'b1;
        #1;
        checkValue("reset_state", 4'd0, 1'b0);
        #5;
        checkValue("reset_edge_hold", 4'd0, 1'b0);
        #4;
        m_reset_ = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge m_clock);
            #1;
            if (eu === 1'b1) euPulses++;
        end
        #4;
        checkValue("longrun_t210", 4'd4, 1'b0);
        checks++;
        if (euPulses != 1) begin
            errors++;
            $display("[TB] FAIL longrun_eu_pulses: got %0d, expected 1", euPulses);
        end

        // Table-driven vectors through the scoreboard.
        for (int i = 0; i < nVec; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].ei, vecs[i].q, vecs[i].eu);
        end

        // Async reset between edges at q=9, then resume from zero.
        @(negedge m_clock);
        #2;
        m_reset_ = 1'b0;
        #1;
        checkValue("async_reset_at9", 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd1, 1'b0);
        for (int k = 2; k <= 15; k++) applyStimulus(1'b1, 1'b1, 4'(k), 1'(k == 15));

        // At q=15, eu must follow m_ei combinationally between edges.
        #1;
        m_ei = 1'b0;
        #1;
        checkValue("eu_comb_ei0", 4'd15, 1'b0);
        m_ei = 1'b1;
        #1;
        checkValue("eu_comb_ei1", 4'd15, 1'b1);

        // Async reset while eu is high must clear the count and drop eu at once.
        @(negedge m_clock);
        #1;
        m_reset_ = 1'b0;
        #1;
        checkValue("async_reset_at15", 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd1, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd2, 1'b0);

        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
